// File: rtl/mem64_arb_ctrl.sv
// Two-port round-robin arbiter/sequencer for the single-port 64x32 cache array.
// Define MEM64_RMW_EN to emulate byte-masked stores by read-modify-write.
module mem64_arb_ctrl #(
   parameter int ADDR_W  = 6,
   parameter int DATA_W  = 32,
   parameter int RR_INIT = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              req_valid,
   output logic [1:0]              req_ready,
   input  logic [1:0]              req_we,
   input  logic [2*ADDR_W-1:0]     req_addr,
   input  logic [2*DATA_W-1:0]     req_wdata,
   input  logic [2*(DATA_W/8)-1:0] req_wmask,
   output logic [1:0]              rsp_valid,
   output logic [DATA_W-1:0]       rsp_rdata,
   output logic                    mem_ce,
   output logic                    mem_we,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [DATA_W-1:0]       mem_idat,
   input  logic [DATA_W-1:0]       mem_odat
);
   localparam int BE_W = DATA_W / 8;

`ifdef MEM64_RMW_EN
   typedef enum logic [1:0] {IDLE, RMW_RD, RMW_WR} state_e;
`else
   typedef enum logic [0:0] {IDLE} state_e;
`endif

   state_e              state_q, state_d;
   logic                prio_q, prio_d;
   logic [1:0]          rd_pend_q, rd_pend_d;
   logic [1:0]          rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
`ifdef MEM64_RMW_EN
   logic [ADDR_W-1:0]   rmw_addr_q, rmw_addr_d;
   logic [DATA_W-1:0]   rmw_wdata_q, rmw_wdata_d;
   logic [BE_W-1:0]     rmw_mask_q, rmw_mask_d;
   logic [DATA_W-1:0]   rmw_merge_q, rmw_merge_d;
`endif

   logic                accept, gnt, g_we;
   logic [ADDR_W-1:0]   g_addr;
   logic [DATA_W-1:0]   g_wdata;
   logic [BE_W-1:0]     g_mask;

   // Both valid: priority port wins; otherwise whichever single port is valid.
   assign gnt     = (req_valid == 2'b11) ? prio_q : req_valid[1];
   assign accept  = (state_q == IDLE) && !rst && (|req_valid);
   assign g_we    = gnt ? req_we[1] : req_we[0];
   assign g_addr  = gnt ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
   assign g_wdata = gnt ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
   assign g_mask  = gnt ? req_wmask[BE_W +: BE_W] : req_wmask[0 +: BE_W];

   assign req_ready = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_valid = rsp_valid_q & {2{~rst}};
   assign rsp_rdata = rsp_rdata_q;

   always_comb begin
      state_d     = state_q;
      prio_d      = prio_q;
      rd_pend_d   = 2'b00;
      rsp_valid_d = rd_pend_q;
      rsp_rdata_d = (|rd_pend_q) ? mem_odat : rsp_rdata_q;
      mem_ce      = 1'b1;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_idat    = '0;
`ifdef MEM64_RMW_EN
      rmw_addr_d  = rmw_addr_q;
      rmw_wdata_d = rmw_wdata_q;
      rmw_mask_d  = rmw_mask_q;
      rmw_merge_d = rmw_merge_q;
`endif
      if (accept) begin
         prio_d = ~gnt;
         if (!g_we) begin
            mem_ce    = 1'b0;
            mem_addr  = g_addr;
            rd_pend_d = req_ready;
         end else if (|g_mask) begin
            mem_ce   = 1'b0;
            mem_addr = g_addr;
`ifdef MEM64_RMW_EN
            if (&g_mask) begin
               mem_we   = 1'b1;
               mem_idat = g_wdata;
            end else begin
               // Issue the read half now; merge lands next cycle from mem_odat.
               rmw_addr_d  = g_addr;
               rmw_wdata_d = g_wdata;
               rmw_mask_d  = g_mask;
               state_d     = RMW_RD;
            end
`else
            mem_we   = 1'b1;
            mem_idat = g_wdata;
`endif
         end
      end
`ifdef MEM64_RMW_EN
      case (state_q)
         RMW_RD: begin
            for (int b = 0; b < BE_W; b++)
               rmw_merge_d[b*8 +: 8] = rmw_mask_q[b] ? rmw_wdata_q[b*8 +: 8] : mem_odat[b*8 +: 8];
            state_d = RMW_WR;
         end
         RMW_WR: begin
            if (!rst) begin
               mem_ce   = 1'b0;
               mem_we   = 1'b1;
               mem_addr = rmw_addr_q;
               mem_idat = rmw_merge_q;
            end
            state_d = IDLE;
         end
         default: ;
      endcase
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         prio_q      <= 1'(RR_INIT);
         rd_pend_q   <= 2'b00;
         rsp_valid_q <= 2'b00;
         rsp_rdata_q <= '0;
`ifdef MEM64_RMW_EN
         rmw_addr_q  <= '0;
         rmw_wdata_q <= '0;
         rmw_mask_q  <= '0;
         rmw_merge_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         prio_q      <= prio_d;
         rd_pend_q   <= rd_pend_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
`ifdef MEM64_RMW_EN
         rmw_addr_q  <= rmw_addr_d;
         rmw_wdata_q <= rmw_wdata_d;
         rmw_mask_q  <= rmw_mask_d;
         rmw_merge_q <= rmw_merge_d;
`endif
      end
   end
endmodule

// File: tb/tb_mem64_arb_ctrl.sv
// Bench for mem64_arb_ctrl: vector table, directed corner sequences and random traffic
// checked each cycle against a transaction-level model (array image + response queue).
module tb_mem64_arb_ctrl;
   localparam int AW = 6, DW = 32, BW = 4;
`ifdef MEM64_RMW_EN
   localparam bit RMW = 1'b1;
`else
   localparam bit RMW = 1'b0;
`endif

   logic          clk = 1'b0, rst;
   logic [1:0]    req_valid, req_ready, req_we, rsp_valid;
   logic [2*AW-1:0] req_addr;
   logic [2*DW-1:0] req_wdata;
   logic [2*BW-1:0] req_wmask;
   logic [DW-1:0] rsp_rdata, mem_idat, mem_odat;
   logic          mem_ce, mem_we;
   logic [AW-1:0] mem_addr;

   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   mem64_arb_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RR_INIT(0)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_ce(mem_ce), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_idat(mem_idat), .mem_odat(mem_odat));

   // Array behaviour: synchronous single port, active-low chip enable.
   logic [DW-1:0] arr [64];
   initial begin
      for (int i = 0; i < 64; i++) arr[i] = '0;
      mem_odat = '0;
   end
   always @(posedge clk)
      if (!mem_ce) begin
         if (mem_we) arr[mem_addr] <= mem_idat;
         else        mem_odat <= arr[mem_addr];
      end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   typedef struct { int due; int port; logic [DW-1:0] data; } rsp_t;
   rsp_t          rq[$];
   logic [DW-1:0] ref_mem [64];
   int            prio = 0, busy = 0, cyc = 0;
   int            rmw_addr = 0;
   logic [DW-1:0] rmw_old = '0, rmw_merged = '0;
   bit            rst_prev = 1'b0;
   initial for (int i = 0; i < 64; i++) ref_mem[i] = '0;

   always @(negedge clk) begin
      int g, a;
      logic [DW-1:0] d, merged;
      logic [BW-1:0] m;
      logic          wr, exp_ce, exp_we;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_idat;
      cyc++;
      if (rst) begin
         chk("rst_ready", req_ready, 0);
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_mem_ce", mem_ce, 1);
         chk("rst_mem_we", mem_we, 0);
         chk("rst_mem_addr", mem_addr, 0);
         chk("rst_mem_idat", mem_idat, 0);
         if (rst_prev) chk("rst_rdata", rsp_rdata, 0);
         if (busy > 0) ref_mem[rmw_addr] = rmw_old;   // interrupted merge never lands
         busy = 0; prio = 0; rq.delete();
      end else begin
         g = -1;
         if (busy == 0) begin
            if (req_valid == 2'b11) g = prio;
            else if (req_valid[0])  g = 0;
            else if (req_valid[1])  g = 1;
         end
         chk("ready", req_ready, (g < 0) ? 0 : (1 << g));
         if (rq.size() > 0 && rq[0].due == cyc) begin
            chk("rsp_valid", rsp_valid, 1 << rq[0].port);
            chk("rsp_rdata", rsp_rdata, rq[0].data);
            void'(rq.pop_front());
         end else
            chk("rsp_idle", rsp_valid, 0);
         exp_ce = 1'b1; exp_we = 1'b0; exp_addr = '0; exp_idat = '0;
         if (g >= 0) begin
            a = int'(req_addr[g*AW +: AW]);
            d = req_wdata[g*DW +: DW];
            m = req_wmask[g*BW +: BW];
            wr = req_we[g];
            prio = 1 - g;
            exp_addr = AW'(a);
            if (!wr) begin
               exp_ce = 1'b0;
               rq.push_back('{cyc + 2, g, ref_mem[a]});
            end else if (m != 0) begin
               exp_ce = 1'b0;
               for (int b = 0; b < BW; b++)
                  merged[b*8 +: 8] = m[b] ? d[b*8 +: 8] : ref_mem[a][b*8 +: 8];
               if (RMW && m != 4'hF) begin
                  rmw_addr = a; rmw_old = ref_mem[a]; rmw_merged = merged;
                  ref_mem[a] = merged; busy = 2;
               end else begin
                  exp_we = 1'b1; exp_idat = d; ref_mem[a] = d;
               end
            end
         end else if (busy > 0) begin
            if (busy == 1) begin
               exp_ce = 1'b0; exp_we = 1'b1; exp_addr = AW'(rmw_addr); exp_idat = rmw_merged;
            end
            busy--;
         end
         chk("mem_ce", mem_ce, exp_ce);
         if (!exp_ce) begin
            chk("mem_we", mem_we, exp_we);
            chk("mem_addr", mem_addr, exp_addr);
            if (exp_we) chk("mem_idat", mem_idat, exp_idat);
         end
      end
      rst_prev = rst;
   end

   // ---------------- stimulus helpers ----------------
   task automatic xfer(input int p, input bit we, input int a, input logic [DW-1:0] d,
                       input logic [BW-1:0] m);
      bit ok = 1'b0;
      req_valid[p] = 1'b1; req_we[p] = we;
      req_addr[p*AW +: AW] = AW'(a); req_wdata[p*DW +: DW] = d; req_wmask[p*BW +: BW] = m;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk);
         ok = req_ready[p];
      end
      chk("xfer_accept", ok, 1);
      @(posedge clk); #1;
      req_valid[p] = 1'b0;
   endtask

   task automatic rd_check(input int p, input int a, input logic [DW-1:0] exp, input string name);
      bit got = 1'b0;
      xfer(p, 1'b0, a, '0, '0);
      for (int i = 0; i < 6 && !got; i++) begin
         @(negedge clk);
         got = rsp_valid[p];
      end
      chk({name, "_rsp_seen"}, got, 1);
      chk(name, rsp_rdata, exp);
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic [1:0] v, we;
      logic [BW-1:0] m0, m1;
      logic [1:0] exp_rdy;
      logic exp_ce;
   } vec_t;
   vec_t tbl [8];

   initial begin
      tbl[0] = '{2'b00, 2'b00, 4'hF, 4'hF, 2'b00, 1'b1};
      tbl[1] = '{2'b11, 2'b00, 4'hF, 4'hF, 2'b01, 1'b0};
      tbl[2] = '{2'b11, 2'b00, 4'hF, 4'hF, 2'b10, 1'b0};
      tbl[3] = '{2'b10, 2'b00, 4'hF, 4'hF, 2'b10, 1'b0};
      tbl[4] = '{2'b10, 2'b00, 4'hF, 4'hF, 2'b10, 1'b0};
      tbl[5] = '{2'b01, 2'b01, 4'h0, 4'hF, 2'b01, 1'b1};
      tbl[6] = '{2'b11, 2'b00, 4'hF, 4'hF, 2'b10, 1'b0};
      tbl[7] = '{2'b01, 2'b01, 4'hF, 4'hF, 2'b01, 1'b0};

      // Reset held two cycles with both ports requesting.
      rst = 1'b1; req_valid = 2'b11; req_we = '0;
      req_addr = '0; req_wdata = '0; req_wmask = '1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0; req_valid = 2'b00;

      req_addr = {6'd2, 6'd1}; req_wdata = {32'h0BAD_F00D, 32'h1234_5678};
      foreach (tbl[i]) begin
         req_valid = tbl[i].v; req_we = tbl[i].we; req_wmask = {tbl[i].m1, tbl[i].m0};
         @(negedge clk);
         chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].exp_rdy);
         chk($sformatf("tbl%0d_ce", i), mem_ce, tbl[i].exp_ce);
         @(posedge clk); #1;
      end
      req_valid = 2'b00; req_we = 2'b00;
      repeat (3) @(posedge clk); #1;

      // Write then read back through the other port.
      xfer(0, 1'b1, 5, 32'hDEAD_BEEF, 4'hF);
      rd_check(1, 5, 32'hDEAD_BEEF, "wr_rd_addr5");

      // Continuous reads on both ports alternate grants.
      req_we = 2'b00; req_addr = {6'd2, 6'd1}; req_valid = 2'b11;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("alternate", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
         @(posedge clk); #1;
      end
      req_valid = 2'b00;
      repeat (3) @(posedge clk); #1;

      // Partial write: stall window, then merged (or full) result.
      xfer(0, 1'b1, 9, 32'h1122_3344, 4'hF);
      xfer(0, 1'b1, 9, 32'hAABB_CCDD, 4'b0101);
      req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[AW +: AW] = 6'd0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rmw_stall", req_ready[1], RMW ? 1'b0 : 1'b1);
         @(posedge clk); #1;
      end
      req_valid = 2'b00;
      repeat (3) @(posedge clk); #1;
      rd_check(0, 9, RMW ? 32'h11BB_33DD : 32'hAABB_CCDD, "rmw_merge");

      // Reset during the merge read abandons the write.
      xfer(0, 1'b1, 9, 32'h1122_3344, 4'hF);
      xfer(0, 1'b1, 9, 32'hAABB_CCDD, 4'b0101);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      rd_check(0, 9, RMW ? 32'h1122_3344 : 32'hAABB_CCDD, "rmw_abandon");

      // Zero-mask write: accepted without touching the array; priority still moves.
      xfer(1, 1'b1, 3, 32'hFFFF_FFFF, 4'h0);
      req_we = 2'b00; req_valid = 2'b11;
      @(negedge clk);
      chk("mask0_next_grant", req_ready, 2'b01);
      @(posedge clk); #1 req_valid = 2'b00;
      repeat (4) @(posedge clk); #1;

      // Random traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         req_valid = 2'($urandom_range(0, 3));
         req_we    = 2'($urandom_range(0, 3));
         for (int p = 0; p < 2; p++) begin
            int r = $urandom_range(0, 3);
            req_addr[p*AW +: AW]  = AW'($urandom_range(0, 7));
            req_wdata[p*DW +: DW] = $urandom;
            req_wmask[p*BW +: BW] = (r == 0) ? 4'h0 : (r == 1) ? 4'hF : BW'($urandom);
         end
         rst = ($urandom_range(0, 99) == 0);
         @(posedge clk); #1;
      end
      rst = 1'b0; req_valid = 2'b00;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("drain_empty", rq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
